// File: rtl/rx_loop_pkg.sv
// Shared definitions for the VLC loop receiver: link constants, FSM state codes and a
// majority-vote helper.
package rx_loop_pkg;

    localparam int unsigned    VlcWidth    = 10;
    localparam int unsigned    VlcSpb      = 8;
    localparam logic [15:0]    VlcSyncWord = 16'hA5C3;

    typedef enum logic [1:0] {
        StHunt = 2'd0,
        StLen  = 2'd1,
        StData = 2'd2
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_loop_slicer.sv
// Sample-to-bit slicer: hysteresis comparator followed by a 3-tap majority filter.
// Two cycles of latency from i_sample to o_bit.
module rx_loop_slicer
    import rx_loop_pkg::*;
#(
    parameter int unsigned      WIDTH  = VlcWidth,
    parameter logic [WIDTH-1:0] THR_HI = 10'h280,
    parameter logic [WIDTH-1:0] THR_LO = 10'h180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_sample,
    output logic             o_bit
);

    logic s_q, s1_q, s2_q, bit_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q   <= 1'b0;
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            bit_q <= 1'b0;
        end else begin
            // Mid-band samples keep the previous decision.
            if (i_sample >= THR_HI) begin
                s_q <= 1'b1;
            end else if (i_sample < THR_LO) begin
                s_q <= 1'b0;
            end
            s1_q  <= s_q;
            s2_q  <= s1_q;
            bit_q <= maj3(s_q, s1_q, s2_q);
        end
    end

    assign o_bit = bit_q;

endmodule

// File: rtl/rx_loop.sv
// VLC loop receiver: slices ADC samples, recovers bit timing, hunts for the sync word and
// deframes a length-prefixed payload into bytes.
module rx_loop
    import rx_loop_pkg::*;
#(
    parameter int unsigned      WIDTH     = VlcWidth,
    parameter int unsigned      SPB       = VlcSpb,
    parameter logic [WIDTH-1:0] THR_HI    = 10'h280,
    parameter logic [WIDTH-1:0] THR_LO    = 10'h180,
    parameter logic [15:0]      SYNC_WORD = VlcSyncWord,
    parameter int unsigned      TIMEOUT   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_rx_in,
    output logic [7:0]       o_rx_data,
    output logic             o_rx_valid,
    output logic             o_sync,
    output logic             o_rx_ind,
    output logic             o_rx_err,
    output logic             o_busy
);

    localparam int unsigned PhW = $clog2(SPB);
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);
    localparam logic [PhW-1:0] DecPh  = PhW'(SPB / 2 - 1);
    localparam logic [PhW-1:0] LastPh = PhW'(SPB - 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

    logic           b;
    logic           b_prev_q;
    logic [PhW-1:0] ph_q;
    logic           bit_edge, dec, wrap;

    rx_state_e      state_q;
    logic [15:0]    sr_q;
    logic [7:0]     byte_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     len_q;
    logic [ToW-1:0] to_q;
    logic [7:0]     data_q;
    logic           valid_q, sync_q, ind_q, err_q;
    logic [15:0]    sr_nxt;
    logic [7:0]     byte_nxt;

    rx_loop_slicer #(
        .WIDTH  (WIDTH),
        .THR_HI (THR_HI),
        .THR_LO (THR_LO)
    ) u_slicer (
        .clk      (clk),
        .reset    (reset),
        .i_sample (i_rx_in),
        .o_bit    (b)
    );

    assign bit_edge = b ^ b_prev_q;
    assign dec      = (ph_q == DecPh);
    assign wrap     = (ph_q == LastPh);
    assign sr_nxt   = {sr_q[14:0], b};
    assign byte_nxt = {byte_q[6:0], b};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_prev_q <= 1'b0;
            ph_q     <= '0;
        end else begin
            b_prev_q <= b;
            ph_q     <= (bit_edge || wrap) ? '0 : ph_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StHunt;
            sr_q      <= '0;
            byte_q    <= '0;
            bit_cnt_q <= '0;
            len_q     <= '0;
            to_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sync_q    <= 1'b0;
            ind_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            ind_q   <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                StHunt: begin
                    if (dec) begin
                        sr_q <= sr_nxt;
                        if (sr_nxt == SYNC_WORD) begin
                            sync_q    <= 1'b1;
                            state_q   <= StLen;
                            bit_cnt_q <= '0;
                            to_q      <= '0;
                        end
                    end
                end
                StLen, StData: begin
                    // Timeout counts whole edge-free bit periods at the phase wrap.
                    if (bit_edge) begin
                        to_q <= '0;
                    end else if (wrap) begin
                        to_q <= to_q + 1'b1;
                    end
                    if (wrap && !bit_edge && to_q == ToLast) begin
                        err_q   <= 1'b1;
                        state_q <= StHunt;
                        sr_q    <= '0;
                    end else if (dec) begin
                        byte_q    <= byte_nxt;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == StLen) begin
                                if (byte_nxt == 8'd0) begin
                                    ind_q   <= 1'b1;
                                    state_q <= StHunt;
                                    sr_q    <= '0;
                                end else begin
                                    len_q   <= byte_nxt;
                                    state_q <= StData;
                                end
                            end else begin
                                data_q  <= byte_nxt;
                                valid_q <= 1'b1;
                                if (len_q == 8'd1) begin
                                    ind_q   <= 1'b1;
                                    state_q <= StHunt;
                                    sr_q    <= '0;
                                end else begin
                                    len_q <= len_q - 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_q <= StHunt;
            endcase
        end
    end

    assign o_rx_data  = data_q;
    assign o_rx_valid = valid_q;
    assign o_sync     = sync_q;
    assign o_rx_ind   = ind_q;
    assign o_rx_err   = err_q;
    assign o_busy     = (state_q != StHunt);

endmodule

// File: tb/tb_rx_loop.sv
// Bench for rx_loop: a tx-side sample model drives frames, expected strobes go to a
// scoreboard queue and are matched as the receiver emits them.
module tb_rx_loop;

    localparam int Spb = 8;
    localparam int EvSync = 0, EvByte = 1, EvByteInd = 2, EvInd = 3, EvErr = 4, EvBad = 5;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0]  len;
        logic [23:0] pl;
        bit          noise;
        int          exp_valid;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] rx_in = 10'h000;
    logic [7:0] rx_data;
    logic       rx_valid, sync, rx_ind, rx_err, busy;

    int  n_cmp = 0;
    int  n_fail = 0;
    int  nvalid = 0;
    ev_t exp_q[$];

    rx_loop dut (
        .clk        (clk),
        .reset      (reset),
        .i_rx_in    (rx_in),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_sync     (sync),
        .o_rx_ind   (rx_ind),
        .o_rx_err   (rx_err),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard: classify each strobe cycle and pop the matching expectation.
    always @(negedge clk) begin
        int  kind;
        ev_t e;
        if (reset && (sync || rx_valid || rx_ind || rx_err)) begin
            if (sync && !rx_valid && !rx_ind && !rx_err)      kind = EvSync;
            else if (rx_valid && rx_ind && !sync && !rx_err)  kind = EvByteInd;
            else if (rx_valid && !rx_ind && !sync && !rx_err) kind = EvByte;
            else if (rx_ind && !rx_valid && !sync && !rx_err) kind = EvInd;
            else if (rx_err && !rx_valid && !sync && !rx_ind) kind = EvErr;
            else                                              kind = EvBad;
            if (rx_valid) nvalid++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got kind %0d expected none", kind);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", kind, e.kind);
                if (e.kind == EvByte || e.kind == EvByteInd) check("rx_data", rx_data, e.data);
            end
        end
    end

    task automatic send_bit(input logic v, input bit noise);
        logic [9:0] s;
        for (int k = 0; k < Spb; k++) begin
            s = v ? 10'h3FF : 10'h000;
            if (noise) begin
                if (!v && k == 2) s = 10'h3FF;
                if (!v && k == 5) s = 10'h200;
                if (v && (k == 1 || k == 4)) s = 10'h200;
            end
            @(negedge clk) rx_in = s;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit noise);
        for (int i = 7; i >= 0; i--) send_bit(v[i], noise);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
    endtask

    task automatic send_header(input logic [7:0] len, input bit noise);
        idle(4);
        send_byte(8'hA5, noise);
        send_byte(8'hC3, noise);
        send_byte(len, noise);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        logic [7:0] by;
        nvalid = 0;
        push(EvSync, 8'h00);
        for (int i = 0; i < int'(v.len); i++) begin
            by = v.pl[23 - 8 * i -: 8];
            push((i == int'(v.len) - 1) ? EvByteInd : EvByte, by);
        end
        if (v.len == 8'd0) push(EvInd, 8'h00);
        send_header(v.len, v.noise);
        for (int i = 0; i < int'(v.len); i++) begin
            by = v.pl[23 - 8 * i -: 8];
            send_byte(by, v.noise);
        end
        idle(4);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_valid_count"}, nvalid, v.exp_valid);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_sync"}, sync, 0);
        check({tag, "_rx_ind"}, rx_ind, 0);
        check({tag, "_rx_err"}, rx_err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{len: 8'd2, pl: 24'h3CFF00, noise: 1'b0, exp_valid: 2};
        vecs[1] = '{len: 8'd0, pl: 24'h000000, noise: 1'b0, exp_valid: 0};
        vecs[2] = '{len: 8'd2, pl: 24'h3CFF00, noise: 1'b1, exp_valid: 2};
        vecs[3] = '{len: 8'd2, pl: 24'hA5C300, noise: 1'b0, exp_valid: 2};
        vecs[4] = '{len: 8'd3, pl: 24'h112233, noise: 1'b1, exp_valid: 3};

        #1;
        check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Timeout: third byte never arrives; second byte decodes as 00 before the abort.
        push(EvSync, 8'h00);
        push(EvByte, 8'h55);
        push(EvByte, 8'h00);
        push(EvErr, 8'h00);
        send_header(8'd3, 1'b0);
        send_byte(8'h55, 1'b0);
        idle(9);
        idle(4);
        check("timeout_queue_empty", exp_q.size(), 0);
        check("timeout_busy_after", busy, 0);
        run_frame(vecs[0], "after_timeout");

        // Asynchronous reset in the middle of the second payload byte.
        push(EvSync, 8'h00);
        push(EvByte, 8'h3C);
        send_header(8'd2, 1'b0);
        send_byte(8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        check("midreset_busy_before", busy, 1);
        check("midreset_data_before", rx_data, 8'h3C);
        #2 reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        check("midreset_queue_empty", exp_q.size(), 0);
        rx_in = 10'h000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        run_frame(vecs[0], "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
